im_fetch: RTL and testbench

//  Instruction-fetch stage sitting directly upstream of im_cached. Owns the PC,

---
 rtl/im_fetch_pkg.sv | 20 ++
 rtl/im_fetch_if_id_reg.sv | 39 +++
 rtl/im_fetch.sv | 120 ++++++++++++
 tb/tb_im_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, defaults
// and the IF/ID register payload.
package im_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_MISS = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } if_id_t;

endpackage

// File: rtl/im_fetch_if_id_reg.sv
// IF/ID pipeline register. Flush turns the slot into a bubble (valid=0, NOP)
// while keeping the address fields; neither load nor flush means hold.
module im_fetch_if_id_reg
   import im_fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   flush,
   input  if_id_t load_val,
   output if_id_t if_id
);

   if_id_t if_id_q;
   if_id_t if_id_d;

   always_comb begin
      if_id_d = if_id_q;
      if (flush) begin
         if_id_d.valid = 1'b0;
         if_id_d.instr = NOP_INSTR;
      end else if (load) begin
         if_id_d = load_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};
      end else begin
         if_id_q <= if_id_d;
      end
   end

   assign if_id = if_id_q;

endmodule

// File: rtl/im_fetch.sv
// Instruction-fetch stage: owns the PC, holds it through cache misses, and
// feeds the IF/ID register. Redirect beats stall beats hit beats miss.
module im_fetch
   import im_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [31:0]      im_addr,
   input  logic             im_hit,
   input  logic [31:0]      im_data,
   input  logic             id_stall,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_pc4,
   output logic             miss_busy,
   output logic             align_err,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [31:0]      pc_q, pc_d, pc_plus4;
   fetch_state_e     state_q, state_d;
   logic             miss_busy_q, miss_busy_d;
   logic             align_err_q, align_err_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic             ifid_load, ifid_flush;
   if_id_t           ifid_in, ifid;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d        = pc_q;
      state_d     = state_q;
      align_err_d = align_err_q;
      fetch_cnt_d = fetch_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      ifid_load   = 1'b0;
      ifid_flush  = 1'b0;
      ifid_in     = '{valid: 1'b1, instr: im_data, pc: pc_q, pc4: pc_plus4};

      if (redirect) begin
         // A pending miss is simply abandoned; the cache sees the new address next cycle.
         pc_d       = redirect_pc;
         ifid_flush = 1'b1;
         state_d    = S_RUN;
         if (redirect_pc[1:0] != 2'b00) begin
            align_err_d = 1'b1;
         end
      end else if (id_stall) begin
         // Everything holds; a fill still completes in the cache and re-hits later.
         pc_d = pc_q;
      end else if (im_hit) begin
         ifid_load = 1'b1;
         pc_d      = pc_plus4;
         state_d   = S_RUN;
         if (fetch_cnt_q != CNT_MAX) begin
            fetch_cnt_d = fetch_cnt_q + CNT_ONE;
         end
      end else begin
         ifid_flush = 1'b1;
         state_d    = S_MISS;
         if (miss_cnt_q != CNT_MAX) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
         end
      end

      miss_busy_d = (state_d == S_MISS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         state_q     <= S_RUN;
         miss_busy_q <= 1'b0;
         align_err_q <= 1'b0;
         fetch_cnt_q <= '0;
         miss_cnt_q  <= '0;
      end else begin
         pc_q        <= pc_d;
         state_q     <= state_d;
         miss_busy_q <= miss_busy_d;
         align_err_q <= align_err_d;
         fetch_cnt_q <= fetch_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   im_fetch_if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ifid_load),
      .flush    (ifid_flush),
      .load_val (ifid_in),
      .if_id    (ifid)
   );

   assign im_addr   = pc_q;
   assign if_valid  = ifid.valid;
   assign if_instr  = ifid.instr;
   assign if_pc     = ifid.pc;
   assign if_pc4    = ifid.pc4;
   assign miss_busy = miss_busy_q;
   assign align_err = align_err_q;
   assign fetch_cnt = fetch_cnt_q;
   assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_im_fetch.sv
// Bench for im_fetch: a small direct-mapped cache model with a fixed miss
// latency feeds the DUT, and a cycle-level reference model checks every output.
module tb_im_fetch;
   import im_fetch_pkg::*;

   localparam int          ND  = 3;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] im_addr, im_data, redirect_pc;
   logic        im_hit, id_stall, redirect;
   logic        if_valid, miss_busy, align_err;
   logic [31:0] if_instr, if_pc, if_pc4, fetch_cnt, miss_cnt;

   logic [31:0] s_addr, s_instr, s_pc, s_pc4;
   logic        s_valid, s_busy, s_align;
   logic [3:0]  s_fetch_cnt, s_miss_cnt;

   im_fetch #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_hit(im_hit), .im_data(im_data),
      .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
      .miss_busy(miss_busy), .align_err(align_err), .fetch_cnt(fetch_cnt), .miss_cnt(miss_cnt)
   );

   // Narrow-counter build that never hits, to reach counter saturation quickly.
   im_fetch #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .im_addr(s_addr), .im_hit(1'b0), .im_data(32'h0),
      .id_stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
      .if_valid(s_valid), .if_instr(s_instr), .if_pc(s_pc), .if_pc4(s_pc4),
      .miss_busy(s_busy), .align_err(s_align), .fetch_cnt(s_fetch_cnt), .miss_cnt(s_miss_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fcnt, m_mcnt;
   logic        m_valid, m_busy, m_align;

   // cache model state
   bit          c_valid [0:15];
   logic [31:0] c_tag [0:15];
   bit          wait_on;
   logic [31:0] wait_addr;
   int          wait_cnt;

   typedef struct {
      bit          rd;
      logic [31:0] rpc;
      bit          st;
      bit          hit;
      logic [31:0] data;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
      bit          e_busy;
   } vec_t;
   vec_t tbl [10];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_busy = 1'b0; m_align = 1'b0; m_fcnt = 32'h0; m_mcnt = 32'h0;
      wait_on = 1'b0; wait_cnt = 0; wait_addr = 32'h0;
   endtask

   task automatic compare_all();
      chk("im_addr", im_addr, m_pc);
      chk("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ipc);
      chk("if_pc4", if_pc4, m_ipc4);
      chk("miss_busy", {31'h0, miss_busy}, {31'h0, m_busy});
      chk("align_err", {31'h0, align_err}, {31'h0, m_align});
      chk("fetch_cnt", fetch_cnt, m_fcnt);
      chk("miss_cnt", miss_cnt, m_mcnt);
   endtask

   // One clock of the stage. fmode=1 drives im_hit/im_data directly; otherwise the cache model answers.
   task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                       input bit fmode, input bit fhit, input logic [31:0] fdata);
      bit          h, fill;
      logic [31:0] d;
      logic [3:0]  idx;
      idx  = m_pc[5:2];
      fill = 1'b0;
      if (fmode) begin
         h = fhit; d = fdata;
      end else begin
         fill = wait_on && (wait_addr == m_pc) && (wait_cnt >= ND);
         h    = (c_valid[idx] && (c_tag[idx] == m_pc)) || fill;
         d    = mem_word(m_pc);
      end
      @(negedge clk);
      id_stall = st; redirect = rd; redirect_pc = rpc; im_hit = h; im_data = d;
      @(posedge clk);
      #1;
      if (!fmode) begin
         if (fill) begin
            c_valid[idx] = 1'b1; c_tag[idx] = m_pc; wait_on = 1'b0;
         end else if (!h) begin
            if (wait_on && wait_addr == m_pc) wait_cnt++;
            else begin wait_on = 1'b1; wait_addr = m_pc; wait_cnt = 1; end
         end
      end
      if (rd) begin
         if (rpc[1:0] != 2'b00) m_align = 1'b1;
         m_pc = rpc; m_valid = 1'b0; m_instr = NOP; m_busy = 1'b0;
      end else if (st) begin
         m_pc = m_pc;
      end else if (h) begin
         m_valid = 1'b1; m_instr = d; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
         m_pc = m_pc + 32'd4; m_busy = 1'b0;
         if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      end else begin
         m_valid = 1'b0; m_instr = NOP; m_busy = 1'b1;
         if (m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
      end
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // Release with stall held so the release edge changes nothing.
   task automatic release_reset();
      @(negedge clk);
      id_stall = 1'b1; redirect = 1'b0; im_hit = 1'b0; rst_n = 1'b1;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h100, 1'b0, NOP, 32'h0, 1'b0};
      tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001, 32'h104, 1'b1, 32'hAAAA_0001, 32'h100, 1'b0};
      tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h104, 1'b0, NOP, 32'h0, 1'b1};
      tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h104, 1'b0, NOP, 32'h0, 1'b1};
      tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1234, 32'h104, 1'b0, NOP, 32'h0, 1'b1};
      tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB_0002, 32'h108, 1'b1, 32'hBBBB_0002, 32'h104, 1'b0};
      tbl[6] = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h9999, 32'h200, 1'b0, NOP, 32'h0, 1'b0};
      tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hCCCC_0003, 32'h204, 1'b1, 32'hCCCC_0003, 32'h200, 1'b0};
      tbl[8] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, NOP, 32'h0, 1'b0};
      tbl[9] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hDDDD_0004, 32'h0, 1'b1, 32'hDDDD_0004, 32'hFFFF_FFFC, 1'b0};

      for (int i = 0; i < 16; i++) begin c_valid[i] = 1'b0; c_tag[i] = 32'h0; end
      id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; im_hit = 1'b0; im_data = 32'h0;
      model_reset();
      #1;
      compare_all();
      release_reset();

      // cold misses: three words, ND bubbles each
      run(12);
      chk("t1_if_pc", if_pc, 32'h8);
      chk("t1_miss_cnt", miss_cnt, 32'd9);
      chk("t1_fetch_cnt", fetch_cnt, 32'd3);
      run(2);
      chk("t1_busy_before_rst", {31'h0, miss_busy}, 32'h1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("t1_rst_busy", {31'h0, miss_busy}, 32'h0);
      chk("t1_rst_addr", im_addr, 32'h0);
      chk("t1_rst_miss_cnt", miss_cnt, 32'h0);
      compare_all();
      release_reset();

      // two passes over 0x0..0xC
      run(7);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         chk("t2_valid", {31'h0, if_valid}, 32'h1);
      end
      chk("t2_fetch_cnt", fetch_cnt, 32'd8);

      // stall at pc=8
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
      run(2);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         chk("t3_if_pc", if_pc, 32'h4);
         chk("t3_addr", im_addr, 32'h8);
         chk("t3_fetch_cnt", fetch_cnt, 32'd10);
         chk("t3_miss_cnt", miss_cnt, 32'd3);
      end
      run(1);
      chk("t3_if_pc_rel", if_pc, 32'h8);

      // redirect during a miss, then redirect together with stall
      run(2);
      chk("t4_busy", {31'h0, miss_busy}, 32'h1);
      chk("t4_addr_miss", im_addr, 32'h10);
      step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      chk("t4_addr", im_addr, 32'h40);
      chk("t4_valid", {31'h0, if_valid}, 32'h0);
      chk("t4_busy_clr", {31'h0, miss_busy}, 32'h0);
      step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
      chk("t4_rd_over_stall", im_addr, 32'h80);

      // misaligned redirect and pc wrap
      step(1'b0, 1'b1, 32'h42, 1'b0, 1'b0, 32'h0);
      chk("t5_align", {31'h0, align_err}, 32'h1);
      run(3);
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      run(4);
      chk("t5_wrap_addr", im_addr, 32'h0);
      chk("t5_wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      chk("t5_wrap_if_pc4", if_pc4, 32'h0);
      chk("t5_align_sticky", {31'h0, align_err}, 32'h1);

      // directed vector table with im_hit driven directly
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].st, tbl[i].rd, tbl[i].rpc, 1'b1, tbl[i].hit, tbl[i].data);
         chk("tbl_addr", im_addr, tbl[i].e_addr);
         chk("tbl_valid", {31'h0, if_valid}, {31'h0, tbl[i].e_valid});
         chk("tbl_instr", if_instr, tbl[i].e_instr);
         chk("tbl_busy", {31'h0, miss_busy}, {31'h0, tbl[i].e_busy});
         if (tbl[i].e_valid) chk("tbl_if_pc", if_pc, tbl[i].e_ipc);
      end

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rpc;
         bit st, rd, h;
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         h   = ($urandom_range(0, 9) < 6);
         rpc = $urandom;
         case ($urandom_range(0, 7))
            0:       rpc = rpc;
            1:       rpc = 32'hFFFF_FFFC;
            default: rpc[1:0] = 2'b00;
         endcase
         step(st, rd, rpc, 1'b1, h, $urandom);
      end

      // narrow counters saturate at all-ones
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_sat_miss_cnt", {28'h0, s_miss_cnt}, 32'hF);
         chk("t6_sat_fetch_cnt", {28'h0, s_fetch_cnt}, 32'h0);
         chk("t6_sat_busy", {31'h0, s_busy}, 32'h1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
